// File: rtl/circuito_exp5.sv
// Genius-style memory game core: control FSM plus datapath (16x4 ROM, play counter,
// play register, comparator, switch edge detector) and 7-segment debug outputs.
module circuito_exp5 (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] chaves,
    output logic       acertou,
    output logic       errou,
    output logic       pronto,
    output logic [3:0] leds,
    output logic       db_igual,
    output logic [6:0] db_contagem,
    output logic [6:0] db_memoria,
    output logic [6:0] db_estado,
    output logic [6:0] db_jogadafeita,
    output logic       db_clock,
    output logic       db_iniciar,
    output logic       db_tem_jogada
);

    localparam int unsigned W_DADO = 4;
    localparam int unsigned W_END  = 4;
    localparam int unsigned W_SEG  = 7;
    localparam logic [W_END-1:0] ULTIMO_END = W_END'(15);

    // State codes double as the digit shown on db_estado
    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        PREPARACAO    = 4'h1,
        ESPERA_JOGADA = 4'h2,
        REGISTRA      = 4'h4,
        COMPARACAO    = 4'h5,
        PROXIMO       = 4'h6,
        FIM_ACERTOU   = 4'hA,
        FIM_ERROU     = 4'hE
    } estado_t;

    estado_t             r_estado;
    estado_t             w_prox_estado;
    logic [W_END-1:0]    r_contagem;
    logic [W_DADO-1:0]   r_jogada;
    logic                r_prev_a;
    logic [W_DADO-1:0]   w_memoria;
    logic                w_a;
    logic                w_jogada;
    logic                w_igual;
    logic                w_fim_contagem;
    logic                w_zera;
    logic                w_conta;
    logic                w_registra;

    function automatic logic [W_DADO-1:0] rom_lookup(input logic [W_END-1:0] addr);
        logic [W_DADO-1:0] dado;
        case (addr)
            4'h0:    dado = 4'b0001;
            4'h1:    dado = 4'b0010;
            4'h2:    dado = 4'b0100;
            4'h3:    dado = 4'b1000;
            4'h4:    dado = 4'b0100;
            4'h5:    dado = 4'b0010;
            4'h6:    dado = 4'b0001;
            4'h7:    dado = 4'b0001;
            4'h8:    dado = 4'b0010;
            4'h9:    dado = 4'b0010;
            4'hA:    dado = 4'b0100;
            4'hB:    dado = 4'b0100;
            4'hC:    dado = 4'b1000;
            4'hD:    dado = 4'b1000;
            4'hE:    dado = 4'b0001;
            default: dado = 4'b0100;
        endcase
        return dado;
    endfunction

    // Active-low segments, bit0 = a ... bit6 = g
    function automatic logic [W_SEG-1:0] hex7seg(input logic [3:0] valor);
        logic [W_SEG-1:0] seg;
        case (valor)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // Edge detector: a play is the first cycle the switches leave all-zero
    assign w_a      = |chaves;
    assign w_jogada = w_a & ~r_prev_a;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_prev_a <= 1'b0;
        else       r_prev_a <= w_a;
    end

    assign w_memoria      = rom_lookup(r_contagem);
    assign w_igual        = (r_jogada == w_memoria);
    assign w_fim_contagem = (r_contagem == ULTIMO_END);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)        r_contagem <= '0;
        else if (w_zera)  r_contagem <= '0;
        else if (w_conta) r_contagem <= r_contagem + W_END'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)           r_jogada <= '0;
        else if (w_zera)     r_jogada <= '0;
        else if (w_registra) r_jogada <= chaves;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_estado <= INICIAL;
        else       r_estado <= w_prox_estado;
    end

    always_comb begin
        w_prox_estado = r_estado;
        case (r_estado)
            INICIAL:       if (iniciar) w_prox_estado = PREPARACAO;
            PREPARACAO:    w_prox_estado = ESPERA_JOGADA;
            ESPERA_JOGADA: if (w_jogada) w_prox_estado = REGISTRA;
            REGISTRA:      w_prox_estado = COMPARACAO;
            COMPARACAO: begin
                if (!w_igual)            w_prox_estado = FIM_ERROU;
                else if (w_fim_contagem) w_prox_estado = FIM_ACERTOU;
                else                     w_prox_estado = PROXIMO;
            end
            PROXIMO:       w_prox_estado = ESPERA_JOGADA;
            FIM_ACERTOU,
            FIM_ERROU:     if (iniciar) w_prox_estado = PREPARACAO;
            default:       w_prox_estado = INICIAL;
        endcase
    end

    // Moore control and end-state outputs decoded from the state register
    always_comb begin
        w_zera     = 1'b0;
        w_conta    = 1'b0;
        w_registra = 1'b0;
        acertou    = 1'b0;
        errou      = 1'b0;
        pronto     = 1'b0;
        case (r_estado)
            PREPARACAO:  w_zera     = 1'b1;
            REGISTRA:    w_registra = 1'b1;
            PROXIMO:     w_conta    = 1'b1;
            FIM_ACERTOU: begin
                acertou = 1'b1;
                pronto  = 1'b1;
            end
            FIM_ERROU: begin
                errou  = 1'b1;
                pronto = 1'b1;
            end
            default: ;
        endcase
    end

    assign leds           = r_jogada;
    assign db_igual       = w_igual;
    assign db_contagem    = hex7seg(r_contagem);
    assign db_memoria     = hex7seg(w_memoria);
    assign db_estado      = hex7seg(r_estado);
    assign db_jogadafeita = hex7seg(r_jogada);
    assign db_clock       = clock;
    assign db_iniciar     = iniciar;
    assign db_tem_jogada  = w_jogada;

endmodule

// File: tb/tb_circuito_exp5.sv
// Self-checking bench for circuito_exp5: directed and randomized games checked
// against a game-level reference model (sequence index, last play, outcome).
module tb_circuito_exp5;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic [3:0] chaves = 4'b0000;
    logic       acertou, errou, pronto, db_igual, db_clock, db_iniciar, db_tem_jogada;
    logic [3:0] leds;
    logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: 0 idle, 1 waiting for play, 2 won, 3 lost
    logic [3:0] ref_rom [16];
    int         m_phase;
    int         m_idx;
    logic [3:0] m_last;

    circuito_exp5 dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
        .acertou(acertou), .errou(errou), .pronto(pronto), .leds(leds),
        .db_igual(db_igual), .db_contagem(db_contagem), .db_memoria(db_memoria),
        .db_estado(db_estado), .db_jogadafeita(db_jogadafeita), .db_clock(db_clock),
        .db_iniciar(db_iniciar), .db_tem_jogada(db_tem_jogada)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] seg(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [3:0] phase_digit(input int ph);
        case (ph)
            1:       return 4'h2;
            2:       return 4'hA;
            3:       return 4'hE;
            default: return 4'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_estado"},  db_estado,   seg(phase_digit(m_phase)));
        chk({tag, "_acertou"}, 7'(acertou), 7'(m_phase == 2));
        chk({tag, "_errou"},   7'(errou),   7'(m_phase == 3));
        chk({tag, "_pronto"},  7'(pronto),  7'(m_phase >= 2));
        chk({tag, "_contagem"}, db_contagem, seg(4'(m_idx)));
        chk({tag, "_memoria"}, db_memoria,  seg(ref_rom[m_idx]));
        chk({tag, "_leds"},    7'(leds),    7'(m_last));
        chk({tag, "_jogfeita"}, db_jogadafeita, seg(m_last));
    endtask

    task automatic model_reset();
        m_phase = 0; m_idx = 0; m_last = 4'b0000;
    endtask

    task automatic start_game(input string tag);
        iniciar = 1'b1;
        cycles(5);
        iniciar = 1'b0;
        cycles(1);
        m_phase = 1; m_idx = 0; m_last = 4'b0000;
        check_all(tag);
    endtask

    // One play held 'hold' (>=4) cycles, then 'gap' idle cycles
    task automatic do_play(input string tag, input logic [3:0] v, input int hold, input int gap);
        logic exp_eq;
        exp_eq = (v == ref_rom[m_idx]);
        chaves = v;
        #1;
        chk({tag, "_pulse"}, 7'(db_tem_jogada), 7'd1);
        cycles(1);
        chk({tag, "_registra"}, db_estado, seg(4'h4));
        cycles(1);
        chk({tag, "_comparacao"}, db_estado, seg(4'h5));
        chk({tag, "_igual"}, 7'(db_igual), 7'(exp_eq));
        chk({tag, "_ledsreg"}, 7'(leds), 7'(v));
        cycles(1);
        chk({tag, "_nopulse"}, 7'(db_tem_jogada), 7'd0);
        cycles(hold - 3);
        chaves = 4'b0000;
        cycles(gap);
        m_last = v;
        if (!exp_eq)          m_phase = 3;
        else if (m_idx == 15) m_phase = 2;
        else                  m_idx++;
        check_all(tag);
    endtask

    initial begin
        int pulses;
        logic [3:0] v;
        ref_rom = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001,
                    4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0100};
        model_reset();

        // Reset and idle
        #2 reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        cycles(10);
        check_all("idle");
        chk("db_iniciar0", 7'(db_iniciar), 7'd0);

        start_game("start1");
        chk("db_iniciar_idle", 7'(db_iniciar), 7'(iniciar));

        // Four correct plays, then a wrong one
        do_play("p0", 4'b0001, 10, 10);
        do_play("p1", 4'b0010, 10, 10);
        do_play("p2", 4'b0100, 10, 10);
        do_play("p3", 4'b1000, 10, 10);
        do_play("p4_wrong", 4'b0001, 10, 10);
        chaves = 4'b0100;
        cycles(6);
        chaves = 4'b0000;
        cycles(2);
        check_all("lost_hold");

        // Full winning game with randomized timing
        start_game("start2");
        for (int i = 0; i < 16; i++)
            do_play("win", ref_rom[i], $urandom_range(4, 8), $urandom_range(1, 4));
        check_all("won");

        // Randomized games mixing correct and wrong plays
        for (int g = 0; g < 4; g++) begin
            start_game("rstart");
            while (m_phase == 1) begin
                if ($urandom_range(0, 4) != 0) v = ref_rom[m_idx];
                else                           v = 4'($urandom_range(1, 15));
                do_play("rnd", v, $urandom_range(4, 8), $urandom_range(1, 4));
            end
            check_all("rend");
        end

        // Reset mid-game at counter 3 aborts at once
        start_game("start3");
        do_play("q0", ref_rom[0], 5, 2);
        do_play("q1", ref_rom[1], 5, 2);
        do_play("q2", ref_rom[2], 5, 2);
        reset = 1'b1;
        #2;
        model_reset();
        check_all("async_rst");
        @(posedge clock);
        #1 reset = 1'b0;
        cycles(2);
        check_all("after_rst");

        // Held switches give exactly one play
        start_game("start4");
        chaves = 4'b0001;
        pulses = 0;
        #1;
        for (int i = 0; i < 10; i++) begin
            if (db_tem_jogada) pulses++;
            cycles(1);
        end
        chaves = 4'b0000;
        cycles(3);
        chk("single_play", 7'(pulses), 7'd1);
        m_last = 4'b0001;
        m_idx  = 1;
        check_all("held");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
